// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI responder for all four modes, oversampled on CLOCK
// Optional macro SPI_SLAVE_LSB_FIRST_EN: LSB-first in both directions.
module spi_slave #(
    parameter int WIDTH       = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLOCK,
    input  logic             RST,
    input  logic             SCK,
    input  logic             SS,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] DATA_in,
    input  logic [6:0]       data_length,
    input  logic [1:0]       M,
    output logic [WIDTH-1:0] DATA_out,
    output logic             rx_valid,
    output logic             tx_load,
    output logic             busy,
    output logic             frame_err
);

    localparam int         IW      = $clog2(WIDTH);
    localparam logic [6:0] WIDTH_L = 7'(WIDTH);

    typedef enum logic [1:0] {IDLE, ACTIVE, LAST} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sck_prev_q, ss_prev_q;
    logic                   sck_s, ss_s, mosi_s;
    logic                   sck_rise, sck_fall, ss_rise, ss_fall;
    logic                   lead_edge, trail_edge, sample_edge, shift_edge;

    state_t           state_q, state_d;
    logic [6:0]       len_q, len_d, bit_cnt_q, bit_cnt_d, len_in, cnt_inc;
    logic             cpol_q, cpol_d, cpha_q, cpha_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             miso_q, miso_d;
    logic             rx_valid_q, rx_valid_d;
    logic             tx_load_q, tx_load_d;
    logic             frame_err_q, frame_err_d;
    logic [IW-1:0]    head_q, head_in;

    function automatic logic [WIDTH-1:0] len_mask(input logic [6:0] len);
        logic [WIDTH-1:0] m;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = (7'(i) < len);
        end
        return m;
    endfunction

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign head_q  = '0;
    assign head_in = '0;

    function automatic logic [WIDTH-1:0] tx_advance(input logic [WIDTH-1:0] v);
        return v >> 1;
    endfunction

    function automatic logic [WIDTH-1:0] rx_push(input logic [WIDTH-1:0] v, input logic b);
        return {b, v[WIDTH-1:1]};
    endfunction

    // Bits enter at the top, so the first bit sits at WIDTH-len after a full word.
    function automatic logic [WIDTH-1:0] rx_align(input logic [WIDTH-1:0] v, input logic [6:0] len);
        return (v >> (WIDTH_L - len)) & len_mask(len);
    endfunction
`else
    assign head_q  = IW'(len_q - 7'd1);
    assign head_in = IW'(len_in - 7'd1);

    function automatic logic [WIDTH-1:0] tx_advance(input logic [WIDTH-1:0] v);
        return v << 1;
    endfunction

    function automatic logic [WIDTH-1:0] rx_push(input logic [WIDTH-1:0] v, input logic b);
        return {v[WIDTH-2:0], b};
    endfunction

    function automatic logic [WIDTH-1:0] rx_align(input logic [WIDTH-1:0] v, input logic [6:0] len);
        return v & len_mask(len);
    endfunction
`endif

    // SS pipeline resets low so a frame already running at reset release never looks like a new SS fall.
    always_ff @(posedge CLOCK or negedge RST) begin
        if (!RST) begin
            sck_sync_q  <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            ss_prev_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            sck_prev_q  <= sck_s;
            ss_prev_q   <= ss_s;
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign ss_s     = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign ss_rise  = ss_s & ~ss_prev_q;
    assign ss_fall  = ~ss_s & ss_prev_q;

    assign lead_edge   = cpol_q ? sck_fall : sck_rise;
    assign trail_edge  = cpol_q ? sck_rise : sck_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;

    assign len_in  = (data_length == 7'd0 || data_length > WIDTH_L) ? WIDTH_L : data_length;
    assign cnt_inc = bit_cnt_q + 7'd1;

    always_ff @(posedge CLOCK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            len_q       <= WIDTH_L;
            bit_cnt_q   <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            data_out_q  <= '0;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            bit_cnt_q   <= bit_cnt_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            data_out_q  <= data_out_d;
            miso_q      <= miso_d;
            rx_valid_q  <= rx_valid_d;
            tx_load_q   <= tx_load_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        bit_cnt_d   = bit_cnt_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        data_out_d  = data_out_q;
        miso_d      = miso_q;
        rx_valid_d  = 1'b0;
        tx_load_d   = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    state_d    = ACTIVE;
                    len_d      = len_in;
                    cpol_d     = M[1];
                    cpha_d     = M[0];
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    tx_load_d  = 1'b1;
                    // tx_shift always holds the next bit to present at its head position.
                    if (M[0]) begin
                        tx_shift_d = DATA_in;
                    end else begin
                        miso_d     = DATA_in[head_in];
                        tx_shift_d = tx_advance(DATA_in);
                    end
                end
            end

            ACTIVE: begin
                if (bit_cnt_q == len_q) begin
                    data_out_d = rx_align(rx_shift_q, len_q);
                    rx_valid_d = 1'b1;
                    bit_cnt_d  = '0;
                    if (ss_rise) begin
                        state_d = IDLE;
                        miso_d  = 1'b0;
                    end else begin
                        tx_load_d = 1'b1;
                        if (cpha_q) begin
                            tx_shift_d = DATA_in;
                        end else begin
                            miso_d     = DATA_in[head_q];
                            tx_shift_d = tx_advance(DATA_in);
                        end
                    end
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = rx_push(rx_shift_q, mosi_s);
                        bit_cnt_d  = cnt_inc;
                    end else if (shift_edge && (cpha_q || bit_cnt_q != 7'd0)) begin
                        // CPHA=0: the trailing edge right after a word boundary keeps the preloaded MSB.
                        miso_d     = tx_shift_q[head_q];
                        tx_shift_d = tx_advance(tx_shift_q);
                    end
                    if (ss_rise) begin
                        miso_d = 1'b0;
                        if (sample_edge && cnt_inc == len_q) begin
                            state_d = LAST;
                        end else begin
                            state_d   = IDLE;
                            bit_cnt_d = '0;
                            if (bit_cnt_q != 7'd0 || sample_edge) begin
                                frame_err_d = 1'b1;
                            end
                        end
                    end
                end
            end

            LAST: begin
                data_out_d = rx_align(rx_shift_q, len_q);
                rx_valid_d = 1'b1;
                bit_cnt_d  = '0;
                miso_d     = 1'b0;
                state_d    = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign MISO      = miso_q;
    assign DATA_out  = data_out_q;
    assign rx_valid  = rx_valid_q;
    assign tx_load   = tx_load_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - scoreboard bench for spi_slave driven by a behavioural SPI master
module tb_spi_slave;

    localparam int WIDTH = 64;
    localparam int SYNC  = 2;
    localparam int HP    = 10;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic             CLOCK, RST, SCK, SS, MOSI, MISO;
    logic [WIDTH-1:0] DATA_in, DATA_out;
    logic [6:0]       data_length;
    logic [1:0]       M;
    logic             rx_valid, tx_load, busy, frame_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_sample = 0;
    int n_rx = 0, n_load = 0, n_ferr = 0;
    logic [63:0] exp_q[$];

    spi_slave #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .CLOCK(CLOCK), .RST(RST), .SCK(SCK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
        .DATA_in(DATA_in), .data_length(data_length), .M(M), .DATA_out(DATA_out),
        .rx_valid(rx_valid), .tx_load(tx_load), .busy(busy), .frame_err(frame_err)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    always @(negedge CLOCK) begin
        if (tx_load) n_load++;
        if (frame_err) n_ferr++;
        if (rx_valid) begin
            n_rx++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_unexpected: got %h want no rx_valid", DATA_out);
            end else begin
                check("rx_data", DATA_out, exp_q.pop_front());
                check("rx_latency", 64'(cyc - last_sample), 64'(SYNC + 2));
            end
        end
    end

    task automatic half();
        repeat (HP) @(posedge CLOCK);
        #1;
    endtask

    task automatic ss_low(input logic [1:0] mode, input logic [6:0] len, input logic [63:0] din);
        M = mode;
        data_length = len;
        DATA_in = din;
        SCK = mode[1];
        half();
        SS = 1'b0;
        half();
    endtask

    task automatic ss_high();
        half();
        SS = 1'b1;
        half();
        half();
    endtask

    task automatic xfer(input logic [1:0] mode, input int nbits, input logic [63:0] word,
                        input bit drop_ss, output logic [63:0] got);
        logic cpol;
        int idx;
        cpol = mode[1];
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = LSB ? i : nbits - 1 - i;
            if (!mode[0]) begin
                MOSI = word[idx];
                half();
                SCK = ~cpol;
                got[idx] = MISO;
                last_sample = cyc;
                if (drop_ss && i == nbits - 1) SS = 1'b1;
                half();
                SCK = cpol;
            end else begin
                half();
                SCK = ~cpol;
                MOSI = word[idx];
                half();
                SCK = cpol;
                got[idx] = MISO;
                last_sample = cyc;
                if (drop_ss && i == nbits - 1) SS = 1'b1;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] got;
        logic [1:0]  modes [3];
        int r0, l0, f0;
        modes[0] = 2'd1;
        modes[1] = 2'd0;
        modes[2] = 2'd3;

        RST = 1'b0; SS = 1'b1; SCK = 1'b0; MOSI = 1'b0;
        DATA_in = '0; data_length = 7'd0; M = 2'd0;
        repeat (3) @(posedge CLOCK);
        #1 RST = 1'b1;
        @(negedge CLOCK);
        check("reset_miso", 64'(MISO), 64'd0);
        check("reset_data_out", DATA_out, 64'd0);
        check("reset_rx_valid", 64'(rx_valid), 64'd0);
        check("reset_tx_load", 64'(tx_load), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_frame_err", 64'(frame_err), 64'd0);

        // mode 2, 32-bit word
        r0 = n_rx; l0 = n_load; f0 = n_ferr;
        exp_q.push_back(64'h00000000FFFFFFC0);
        ss_low(2'd2, 7'd32, 64'hA5A5A5A5);
        check("t1_busy_active", 64'(busy), 64'd1);
        xfer(2'd2, 32, 64'hFFFFFFC0, 1'b0, got);
        ss_high();
        check("t1_miso_word", got, 64'hA5A5A5A5);
        check("t1_rx_count", 64'(n_rx - r0), 64'd1);
        check("t1_load_count", 64'(n_load - l0), 64'd2);
        check("t1_ferr_count", 64'(n_ferr - f0), 64'd0);
        check("t1_busy_idle", 64'(busy), 64'd0);

        // modes 1, 0, 3 with an 8-bit word
        for (int k = 0; k < 3; k++) begin
            r0 = n_rx;
            exp_q.push_back(64'h4F);
            ss_low(modes[k], 7'd8, 64'h3C);
            xfer(modes[k], 8, 64'h4F, 1'b0, got);
            ss_high();
            check("t2_miso_word", got, 64'h3C);
            check("t2_rx_count", 64'(n_rx - r0), 64'd1);
        end

        // back-to-back words, SS released together with the final sample edge
        r0 = n_rx; l0 = n_load; f0 = n_ferr;
        exp_q.push_back(64'h11);
        exp_q.push_back(64'h22);
        ss_low(2'd0, 7'd8, 64'h5A);
        DATA_in = 64'h99;
        xfer(2'd0, 8, 64'h11, 1'b0, got);
        check("t3_miso_word1", got, 64'h5A);
        xfer(2'd0, 8, 64'h22, 1'b1, got);
        check("t3_miso_word2", got, 64'h99);
        ss_high();
        check("t3_rx_count", 64'(n_rx - r0), 64'd2);
        check("t3_load_count", 64'(n_load - l0), 64'd2);
        check("t3_ferr_count", 64'(n_ferr - f0), 64'd0);

        // SS released mid-word
        r0 = n_rx; f0 = n_ferr;
        ss_low(2'd0, 7'd16, 64'h1234);
        xfer(2'd0, 5, 64'h15, 1'b0, got);
        ss_high();
        check("t4_ferr_count", 64'(n_ferr - f0), 64'd1);
        check("t4_rx_count", 64'(n_rx - r0), 64'd0);
        check("t4_data_kept", DATA_out, 64'h22);
        exp_q.push_back(64'hBEEF);
        ss_low(2'd0, 7'd16, 64'h1234);
        xfer(2'd0, 16, 64'hBEEF, 1'b0, got);
        ss_high();
        check("t4_miso_word", got, 64'h1234);

        // data_length 0 means a full 64-bit word
        exp_q.push_back(64'h0123456789ABCDEF);
        ss_low(2'd3, 7'd0, 64'hFEDCBA9876543210);
        xfer(2'd3, 64, 64'h0123456789ABCDEF, 1'b0, got);
        ss_high();
        check("t5_miso_word", got, 64'hFEDCBA9876543210);

        // reset mid-frame
        r0 = n_rx; f0 = n_ferr;
        ss_low(2'd0, 7'd8, 64'hC3);
        xfer(2'd0, 3, 64'h5, 1'b0, got);
        RST = 1'b0;
        #1;
        check("t6_miso", 64'(MISO), 64'd0);
        check("t6_data_out", DATA_out, 64'd0);
        check("t6_rx_valid", 64'(rx_valid), 64'd0);
        check("t6_tx_load", 64'(tx_load), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_frame_err", 64'(frame_err), 64'd0);
        half();
        RST = 1'b1;
        xfer(2'd0, 8, 64'h77, 1'b0, got);
        check("t6_busy_after", 64'(busy), 64'd0);
        ss_high();
        check("t6_rx_count", 64'(n_rx - r0), 64'd0);
        check("t6_ferr_count", 64'(n_ferr - f0), 64'd0);
        exp_q.push_back(64'h5C);
        ss_low(2'd0, 7'd8, 64'h81);
        xfer(2'd0, 8, 64'h5C, 1'b0, got);
        ss_high();
        check("t6_miso_word", got, 64'h81);
        check("t6_rx_recover", 64'(n_rx - r0), 64'd1);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
